// File: rtl/d_reg_pipe_reset_preset_if.sv
// Data/control bundle for the d_reg_pipe_reset_preset register pipeline.
// master = producer/consumer side, slave = the pipeline itself.
interface d_reg_pipe_reset_preset_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 2
);
    logic             clear_in;
    logic             preset_in;
    logic             en_in;
    logic [WIDTH-1:0] d_in;
    logic             valid_in;
    logic [WIDTH-1:0] q_out;
    logic             valid_out;
    logic [CNT_W-1:0] count_out;

    modport master (
        output clear_in, preset_in, en_in, d_in, valid_in,
        input  q_out, valid_out, count_out
    );

    modport slave (
        input  clear_in, preset_in, en_in, d_in, valid_in,
        output q_out, valid_out, count_out
    );
endinterface

// File: rtl/d_reg_pipe_reset_preset.sv
// WIDTH-bit, DEPTH-stage registered delay line with per-stage valid bits,
// stall, flush, preset-to-constant and a registered occupancy count.
module d_reg_pipe_reset_preset #(
    parameter int               WIDTH      = 8,
    parameter int               DEPTH      = 3,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter logic [WIDTH-1:0] PRESET_VAL = WIDTH'(8'hA5),
    parameter int               CNT_W      = $clog2(DEPTH+1)
) (
    input  logic                      clk,
    input  logic                      reset_in,
    d_reg_pipe_reset_preset_if.slave  bus
);
    logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
    logic [DEPTH-1:0]            vld_q, vld_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        cnt_d  = cnt_q;
        if (bus.clear_in) begin
            data_d = {DEPTH{RESET_VAL}};
            vld_d  = '0;
            cnt_d  = '0;
        end else if (bus.preset_in) begin
            data_d = {DEPTH{PRESET_VAL}};
            vld_d  = '1;
            cnt_d  = CNT_W'(DEPTH);
        end else if (bus.en_in) begin
            data_d[0] = bus.d_in;
            vld_d[0]  = bus.valid_in;
            for (int i = 1; i < DEPTH; i++) begin
                data_d[i] = data_q[i-1];
                vld_d[i]  = vld_q[i-1];
            end
            // One entry in, the last stage's entry out: count stays equal to popcount(vld_q).
            cnt_d = cnt_q + CNT_W'(bus.valid_in) - CNT_W'(vld_q[DEPTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            data_q <= {DEPTH{RESET_VAL}};
            vld_q  <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.q_out     = data_q[DEPTH-1];
    assign bus.valid_out = vld_q[DEPTH-1];
    assign bus.count_out = cnt_q;
endmodule
